// File: rtl/hilo_unit.sv
// HI/LO register unit: iterative radix-2 multiply and restoring divide with
// sign fix-up, plus direct MTHI/MTLO writes. One operand bit per cycle.
module hilo_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER + 1);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic            signed_op;

    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] a_raw;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // The magnitude of the most negative value is 2^(WIDTH-1), which still
    // fits an unsigned WIDTH-bit field, so no extra bit is needed here.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        if (is_signed && (sv < 0))
            return $unsigned(-sv);
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign_w(input logic [WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_2w(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
        return neg ? -v : v;
    endfunction

    assign signed_op = ~op[0];

    always_comb begin
        mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
    end

    always_comb begin
        product   = {acc_hi[WIDTH-1:0], acc_lo};
        product_s = apply_sign_2w(product, neg_q);
        res_hi    = product_s[2*WIDTH-1:WIDTH];
        res_lo    = product_s[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = apply_sign_w(acc_hi[WIDTH-1:0], neg_r);
                res_lo = apply_sign_w(acc_lo, neg_q);
            end
        end
    end

    // Control and architectural state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            state    <= CALC;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            is_div   <= op[1];
                            neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r    <= signed_op & a[WIDTH-1];
                            div_zero <= (b == '0);
                        end else if (op == OP_MTHI) begin
                            hi   <= a;
                            done <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo   <= a;
                            done <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1))
                        state <= FIX;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Iteration datapath; only ever consumed through the FIX write, so an
    // aborted operation leaves nothing visible.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start && !op[2]) begin
                    acc_hi <= '0;
                    acc_lo <= magnitude(a, signed_op);
                    mcand  <= magnitude(b, signed_op);
                    a_raw  <= a;
                end
            end
            CALC: begin
                if (!is_div) begin
                    acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                end else begin
                    acc_hi <= div_ge ? (div_shift - {1'b0, mcand}) : div_shift;
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                end
            end
            default: ;
        endcase
    end

endmodule
